// File: rtl/cycle_mon.sv
// cycle_mon: receive-side checker for the switch-core phase counter.
// Hunts phase 0, qualifies LOCK_FRAMES periods, then tracks lock.
//
// Ports:
//   in_clk, in_rst      clock, async active-low reset
//   in_init_done        low forces IDLE
//   in_cycle_cnt        phase count under check
//   in_err_clr          pulse clearing out_err / out_err_cnt
//   out_locked          high while locked
//   out_phase           one-hot phase strobe while locked
//   out_frame_cnt       good periods completed while locked (wraps)
//   out_err             sticky sequence-error flag
//   out_err_cnt         saturating error count
//
// Build option: define CYCLE_MON_ERR_CNT_EN to implement out_err_cnt;
// when it is undefined the counter is removed and out_err_cnt reads 0.
module cycle_mon #(
   parameter int PERIOD      = 3,
   parameter int LOCK_FRAMES = 2,
   parameter int FRM_W       = 16,
   parameter int ERR_W       = 8
) (
   input  logic              in_clk,
   input  logic              in_rst,
   input  logic              in_init_done,
   input  logic [3:0]        in_cycle_cnt,
   input  logic              in_err_clr,
   output logic              out_locked,
   output logic [PERIOD-1:0] out_phase,
   output logic [FRM_W-1:0]  out_frame_cnt,
   output logic              out_err,
   output logic [ERR_W-1:0]  out_err_cnt
);

   typedef enum logic [1:0] {
      IDLE,
      HUNT,
      SYNC,
      LOCKED
   } state_t;

   localparam int GW = $clog2(LOCK_FRAMES + 1);
   localparam logic [3:0] LAST = 4'(PERIOD - 1);
   localparam logic [GW-1:0] LF = GW'(LOCK_FRAMES);
   localparam logic [PERIOD-1:0] ONE = PERIOD'(1);
   localparam logic [3:0] AFTER0 = (LAST == 4'd0) ? 4'd0 : 4'd1;

   state_t            state_q, state_d;
   logic [3:0]        exp_q, exp_d;
   logic [GW-1:0]     good_q, good_d;
   logic              locked_q, locked_d;
   logic [PERIOD-1:0] phase_q, phase_d;
   logic [FRM_W-1:0]  frm_q, frm_d;
   logic              err_q, err_d;
   logic              err_ev;
   logic              match;
   logic [3:0]        exp_inc;
   logic [GW-1:0]     good_inc;

   // exp only ever holds 0..PERIOD-1, so out-of-range inputs never match
   assign match    = (in_cycle_cnt == exp_q);
   assign exp_inc  = (exp_q == LAST) ? 4'd0 : exp_q + 4'd1;
   assign good_inc = good_q + GW'(1);

   always_comb begin
      state_d  = state_q;
      exp_d    = exp_q;
      good_d   = good_q;
      locked_d = locked_q;
      phase_d  = '0;
      frm_d    = frm_q;
      err_ev   = 1'b0;
      if (!in_init_done) begin
         state_d  = IDLE;
         good_d   = '0;
         locked_d = 1'b0;
         frm_d    = '0;
      end else begin
         unique case (state_q)
            IDLE: state_d = HUNT;
            HUNT: begin
               if (in_cycle_cnt == 4'd0) begin
                  exp_d   = AFTER0;
                  good_d  = '0;
                  state_d = SYNC;
               end
            end
            SYNC: begin
               if (match) begin
                  exp_d = exp_inc;
                  if (exp_q == LAST) begin
                     good_d = good_inc;
                     if (good_inc == LF) begin
                        state_d  = LOCKED;
                        locked_d = 1'b1;
                     end
                  end
               end else begin
                  state_d = HUNT;
                  good_d  = '0;
               end
            end
            LOCKED: begin
               if (match) begin
                  phase_d = ONE << in_cycle_cnt;
                  exp_d   = exp_inc;
                  if (exp_q == LAST)
                     frm_d = frm_q + FRM_W'(1);
               end else begin
                  // bad sample is dropped; hunting restarts next edge
                  state_d  = HUNT;
                  locked_d = 1'b0;
                  err_ev   = 1'b1;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // clear first, then the event, so a collision leaves the flag set
   assign err_d = err_ev | (err_q & ~in_err_clr);

   always_ff @(posedge in_clk or negedge in_rst) begin
      if (!in_rst) begin
         state_q  <= IDLE;
         exp_q    <= '0;
         good_q   <= '0;
         locked_q <= 1'b0;
         phase_q  <= '0;
         frm_q    <= '0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         exp_q    <= exp_d;
         good_q   <= good_d;
         locked_q <= locked_d;
         phase_q  <= phase_d;
         frm_q    <= frm_d;
         err_q    <= err_d;
      end
   end

`ifdef CYCLE_MON_ERR_CNT_EN
   logic [ERR_W-1:0] ecnt_q, ecnt_d, ecnt_base;

   assign ecnt_base = in_err_clr ? '0 : ecnt_q;

   always_comb begin
      ecnt_d = ecnt_base;
      if (err_ev && (ecnt_base != '1))
         ecnt_d = ecnt_base + ERR_W'(1);
   end

   always_ff @(posedge in_clk or negedge in_rst) begin
      if (!in_rst)
         ecnt_q <= '0;
      else
         ecnt_q <= ecnt_d;
   end

   assign out_err_cnt = ecnt_q;
`else
   assign out_err_cnt = '0;
`endif

   assign out_locked    = locked_q;
   assign out_phase     = phase_q;
   assign out_frame_cnt = frm_q;
   assign out_err       = err_q;

endmodule
